sipo: RTL and testbench
=======================

// Module: sipo
// PURPOSE
//   Serial-in, parallel-out shift register. Captures one serial bit per enabled clock edge.
//   Presents the accumulated WIDTH-bit word in parallel.
//   Used as the receive side of bit-serial links, where a word arrives MSB first over WIDTH load strobes.
// PARAMETERS
//   WIDTH  42  parallel word width in bits; legal range WIDTH >= 2
// PORTS
//   clk       input   1      sole clock; all state updates on rising edge
//   rst       input   1      reset, asynchronous, active-high
//   load      input   1      shift enable; data_in is sampled on a clk rise when load=1
//   data_in   input   1      serial data bit; don't-care (may be X) when load=0
//   data_out  output  WIDTH  parallel shift-register contents, driven directly from flops
//   bit_cnt   output  CW     (SIPO_BIT_COUNT_EN only) bits captured in current word; CW=$clog2(WIDTH)
//   word_vld  output  1      (SIPO_BIT_COUNT_EN only) one-cycle pulse when a word completes
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - rst=1: data_out <= 0 immediately, without waiting for clk. Optional bit_cnt <= 0 and word_vld <= 0.
//   - The register holds while rst=1. The first shift happens on the first clk rise after rst falls, with load=1.
//   - Rising clk edge, load=1: data_out <= {data_out[WIDTH-2:0], data_in}.
//     The shift goes toward the MSB, and the new bit enters at bit 0.
//   - Rising clk edge, load=0: data_out holds. data_in is ignored, including X values.
//   - Latency: a bit sampled at edge N is visible at data_out[0] after edge N.
//   - After WIDTH consecutive loads of v[WIDTH-1]..v[0] (MSB first), data_out == v.
//     Load strobes need not be contiguous; idle cycles of any length between strobes are allowed.
//   - The oldest bit is discarded from data_out[WIDTH-1] on every shift. There is no overflow flag in the base build.
//   - Loading continuously past WIDTH bits behaves as a sliding window over the last WIDTH bits.
//   - Reset asserted mid-word discards the partial word. The next load starts a fresh word.
//   - No combinational path exists from any input to data_out.
// CONFIGURATION
//   Macro SIPO_BIT_COUNT_EN, when defined:
//   - Adds bit_cnt and word_vld, both registered and both reset to 0.
//   - On each clk rise with load=1:
//     - bit_cnt increments.
//     - When bit_cnt == WIDTH-1, bit_cnt wraps to 0 and word_vld <= 1 for exactly one cycle.
//     - That is the same edge that captures the word's last bit, so data_out holds the full word while word_vld=1.
//   - word_vld is 0 on every other cycle, including load=0 cycles.
//   - Back-to-back words with load held high pulse word_vld every WIDTH cycles.
//   Macro SIPO_BIT_COUNT_EN, when undefined:
//   - The ports bit_cnt and word_vld do not exist, and no counter logic is generated.
//   - The shift path is identical in both builds.
// STRUCTURE
//   - sipo_pkg holds the shared definitions:
//     - function sipo_cnt_w(WIDTH) = (WIDTH>1) ? $clog2(WIDTH) : 1;
//     - localparam defaults: SIPO_DEF_WIDTH=42;
//     - typedef of the counter type, sized by sipo_cnt_w.
//   - Sub-module sipo_bit_counter (WIDTH; clk, rst, en, cnt, wrap) provides the modulo-WIDTH counter and wrap pulse.
//     It is instantiated only under SIPO_BIT_COUNT_EN.
//   - The shift register is a single always block with async reset inside sipo.
//   - Elaboration check: fatal error if WIDTH < 2.
// TESTING
//   - Reset: assert rst mid-cycle with data_out nonzero. data_out must read 0 before the next clk rise.
//   - Word load: with WIDTH=42, shift 42'h2AA_5555_AAAA MSB first, using a random 5..21 idle cycles before each strobe.
//     Sample data_out one clk after the last strobe; it must equal 42'h2AA_5555_AAAA.
//   - Hold: drive load=0 and data_in=X for 50 cycles. data_out must stay unchanged and X-free.
//   - Sliding window: load 44 bits of 1 followed by 1,0 with load held high. data_out must equal {40{1'b1},2'b10}.
//   - Mid-word reset: load 10 bits, pulse rst, then load a full new word. data_out must equal the new word only.
//   - SIPO_BIT_COUNT_EN: load 84 bits continuously.
//     word_vld must pulse exactly at bit 42 and at bit 84, and bit_cnt must read 0 after each pulse.

Source files
------------

// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//   Definitions shared by the serial-in, parallel-out receiver.
//   - SIPO_DEF_WIDTH : default parallel word width
//   - sipo_cnt_w()   : width of the bit counter for a given word width
//   - sipo_cnt_t     : counter type sized for the default width
//   Optional feature macro used by the including files: SIPO_BIT_COUNT_EN.
// -----------------------------------------------------------------------------
package sipo_pkg;

   localparam int SIPO_DEF_WIDTH = 42;

   // A counter must hold the values 0 .. width-1. Never go below one bit.
   function automatic int sipo_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   typedef logic [sipo_cnt_w(SIPO_DEF_WIDTH)-1:0] sipo_cnt_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// -----------------------------------------------------------------------------
// sipo_bit_counter
//   Modulo-WIDTH counter of captured bits, with a registered one-cycle wrap
//   pulse raised on the edge that takes the count from WIDTH-1 back to 0.
//   Used by sipo only when SIPO_BIT_COUNT_EN is defined.
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   en    in   count enable (one captured bit)
//   cnt   out  [CW-1:0] bits captured in the current word
//   wrap  out  one-cycle pulse on the edge that completes a word
// -----------------------------------------------------------------------------
module sipo_bit_counter
   import sipo_pkg::*;
#(
   parameter  int WIDTH = SIPO_DEF_WIDTH,
   localparam int CW    = sipo_cnt_w(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap_q, wrap_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no branch
      // can leave a value unassigned and infer a latch.
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (en) begin
         if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/sipo.sv
// -----------------------------------------------------------------------------
// sipo
//   Serial-in, parallel-out shift register. One serial bit is captured on each
//   rising clk edge with load=1; a word arrives MSB first and ends up with its
//   first bit at data_out[WIDTH-1]. Loading past WIDTH bits keeps a sliding
//   window of the most recent WIDTH bits.
// Configuration
//   SIPO_BIT_COUNT_EN : adds bit_cnt / word_vld, driven by sipo_bit_counter.
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   load      in   shift enable
//   data_in   in   serial bit, ignored when load=0
//   data_out  out  [WIDTH-1:0] shift-register contents (straight from flops)
//   bit_cnt   out  [CW-1:0] bits captured in current word (optional)
//   word_vld  out  one-cycle pulse when a word completes (optional)
// -----------------------------------------------------------------------------
module sipo
   import sipo_pkg::*;
#(
   parameter  int WIDTH = SIPO_DEF_WIDTH
`ifdef SIPO_BIT_COUNT_EN
   ,
   localparam int CW    = sipo_cnt_w(WIDTH)
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             data_in,
`ifdef SIPO_BIT_COUNT_EN
   output logic [CW-1:0]    bit_cnt,
   output logic             word_vld,
`endif
   output logic [WIDTH-1:0] data_out
);

   generate
      if (WIDTH < 2) begin : g_width_check
         $fatal(1, "sipo: WIDTH must be >= 2, got %0d", WIDTH);
      end
   endgenerate

   logic [WIDTH-1:0] data_q;

   // New bits enter at bit 0 and age toward the MSB; the oldest bit falls off
   // the top on every shift. data_in is not looked at when load=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= {data_q[WIDTH-2:0], data_in};
      end
   end

   assign data_out = data_q;

`ifdef SIPO_BIT_COUNT_EN
   sipo_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .en   (load),
      .cnt  (bit_cnt),
      .wrap (word_vld)
   );
`endif

endmodule

// File: tb/tb_sipo.sv
// -----------------------------------------------------------------------------
// tb_sipo
//   Self-checking bench for sipo. A queue of the most recent WIDTH captured bits
//   is the reference; a compare process checks data_out (and, with
//   SIPO_BIT_COUNT_EN, bit_cnt / word_vld) on every falling clk edge, and the
//   directed phases pin the reference with literal words.
// -----------------------------------------------------------------------------
module tb_sipo;

   localparam int WIDTH = 42;

   logic             clk = 1'b0;
   logic             rst;
   logic             load;
   logic             data_in;
   logic [WIDTH-1:0] data_out;
`ifdef SIPO_BIT_COUNT_EN
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0]    bit_cnt;
   logic             word_vld;
`endif

   int total = 0;
   int bad   = 0;

   // Reference: captured bits, oldest first, at most WIDTH entries.
   bit q[$];
   int n_mod = 0;     // loads since reset, modulo WIDTH
   bit vld_m = 1'b0;  // expected word_vld after the latest edge

   sipo #(
      .WIDTH (WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .data_in  (data_in),
`ifdef SIPO_BIT_COUNT_EN
      .bit_cnt  (bit_cnt),
      .word_vld (word_vld),
`endif
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Newest bit lands at position 0, the oldest retained bit at the top.
   function automatic logic [WIDTH-1:0] model_word();
      logic [WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < q.size(); i++) w[q.size() - 1 - i] = q[i];
      return w;
   endfunction

   // One clock: drive inputs after the falling edge, update the model at the rise.
   task automatic drive(input logic l, input logic d);
      @(negedge clk);
      load    = l;
      data_in = d;
      @(posedge clk);
      if (l) begin
         q.push_back(d);
         if (q.size() > WIDTH) void'(q.pop_front());
         n_mod = (n_mod + 1) % WIDTH;
         vld_m = (n_mod == 0);
      end else begin
         vld_m = 1'b0;
      end
   endtask

   // Raise rst in the middle of a low clock phase; the clear must not wait for clk.
   task automatic do_reset();
      @(negedge clk);
      load    = 1'b0;
      data_in = 1'b0;
      #2 rst = 1'b1;
      #1 check("async reset clears", data_out, 64'h0);
      q.delete();
      n_mod = 0;
      vld_m = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      check("cycle data_out", data_out, model_word());
`ifdef SIPO_BIT_COUNT_EN
      check("cycle bit_cnt", bit_cnt, n_mod);
      check("cycle word_vld", word_vld, vld_m);
`endif
   end

   initial begin
      logic [WIDTH-1:0] w1, w2, snap, win;
      rst     = 1'b1;
      load    = 1'b0;
      data_in = 1'b0;
      #1 check("reset state", data_out, 64'h0);
      #13 rst = 1'b0;

      // Word load with random idle gaps before every strobe.
      w1 = 42'h2AA_5555_AAAA;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         repeat ($urandom_range(5, 21)) drive(1'b0, 1'bx);
         drive(1'b1, w1[i]);
      end
      #1;
      check("word load", data_out, w1);
      check("model word load", model_word(), w1);

      // Hold with X on data_in.
      snap = data_out;
      repeat (50) drive(1'b0, 1'bx);
      #1;
      check("hold value", data_out, snap);
      check("hold x-free", $isunknown(data_out), 0);

      // Asynchronous reset with a nonzero register.
      check("pre-reset nonzero", data_out != '0, 1);
      do_reset();

      // Sliding window: 44 ones then 1,0 with load held high.
      repeat (44) drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b0);
      #1;
      win = {{40{1'b1}}, 2'b10};
      check("sliding window", data_out, win);

      // Mid-word reset: partial word must vanish.
      repeat (10) drive(1'b1, 1'($urandom));
      do_reset();
      w2 = 42'h155_AAAA_5555;
      for (int i = WIDTH - 1; i >= 0; i--) drive(1'b1, w2[i]);
      #1;
      check("new word after reset", data_out, w2);

      // Random traffic with occasional resets.
      repeat (400) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         else drive(1'($urandom), 1'($urandom));
      end

`ifdef SIPO_BIT_COUNT_EN
      begin
         int hits[$];
         do_reset();
         for (int i = 1; i <= 2 * WIDTH; i++) begin
            drive(1'b1, 1'($urandom));
            #1;
            if (word_vld === 1'b1) begin
               hits.push_back(i);
               check("bit_cnt after pulse", bit_cnt, 0);
            end
         end
         check("word_vld pulse count", hits.size(), 2);
         if (hits.size() >= 1) check("first pulse at bit", hits[0], WIDTH);
         if (hits.size() >= 2) check("second pulse at bit", hits[1], 2 * WIDTH);
      end
`endif

      repeat (2) drive(1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
